// File: rtl/game_tick_ctrl.sv
// Game control stage: press-edge detection, switch synchronisation,
// IDLE/RUN/PAUSE state machine and a speed-scaled game tick.
module game_tick_ctrl #(
  parameter int unsigned BASE_DIV = 4_000_000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  enter_in,
  input  logic [2:0]  speed_in,
  input  logic        stop_in,
  output logic [2:0]  press_out,
  output logic        tick_out,
  output logic [15:0] tick_count,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] BASE      = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(BASE_DIV - 1);

  state_t           state;
  logic [2:0]       speed_meta;
  logic [2:0]       speed_s;
  logic             stop_meta;
  logic             stop_s;
  logic [2:0]       enter_prev;
  logic [2:0]       press_edge;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload_val;

  // Speed and stop are raw switches; two flops each before any use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_meta <= 3'b000;
      speed_s    <= 3'b000;
      stop_meta  <= 1'b0;
      stop_s     <= 1'b0;
    end else begin
      speed_meta <= speed_in;
      speed_s    <= speed_meta;
      stop_meta  <= stop_in;
      stop_s     <= stop_meta;
    end
  end

  // Resetting to all-ones hides buttons that were held through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_prev <= 3'b111;
    end else begin
      enter_prev <= enter_in;
    end
  end

  assign press_edge = enter_in & ~enter_prev;
  assign reload_val = (BASE >> speed_s) - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= RESET_CNT;
      press_out  <= 3'b000;
      tick_out   <= 1'b0;
      tick_count <= 16'd0;
    end else begin
      press_out <= 3'b000;
      tick_out  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= reload_val;
          // The starting press is consumed here, never forwarded.
          if ((|press_edge) && !stop_s) begin
            state <= RUN;
          end
        end
        RUN: begin
          press_out <= press_edge;
          if (cnt == '0) begin
            tick_out   <= 1'b1;
            tick_count <= tick_count + 16'd1;
            cnt        <= reload_val;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
          if (stop_s) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (!stop_s) begin
            state <= RUN;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= reload_val;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Directed scoreboard bench for game_tick_ctrl with BASE_DIV = 128.
module tb_game_tick_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  typedef struct {
    string       tag;
    logic [21:0] val;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  enter_in;
  logic [2:0]  speed_in;
  logic        stop_in;
  logic [2:0]  press_out;
  logic        tick_out;
  logic [15:0] tick_count;
  logic [1:0]  state_out;

  exp_t        exp_q[$];
  int          errors;
  int          checks;
  logic [15:0] exp_count;

  game_tick_ctrl #(.BASE_DIV(128), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .enter_in   (enter_in),
    .speed_in   (speed_in),
    .stop_in    (stop_in),
    .press_out  (press_out),
    .tick_out   (tick_out),
    .tick_count (tick_count),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] press,
                          input logic tick, input logic [1:0] state,
                          input logic [15:0] count);
    exp_t e;
    e.tag = tag;
    e.val = {press, tick, state, count};
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t        e;
    logic [21:0] obs;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("[TB] FAIL scoreboard_empty: observed=%0d entries expected=1", exp_q.size());
    end else begin
      e   = exp_q.pop_front();
      obs = {press_out, tick_out, state_out, tick_count};
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("[TB] FAIL %s: observed press=%b tick=%b state=%b count=%h expected press=%b tick=%b state=%b count=%h",
               e.tag, obs[21:19], obs[18], obs[17:16], obs[15:0],
               e.val[21:19], e.val[18], e.val[17:16], e.val[15:0]);
      end
    end
  endtask

  task automatic step_check(input string tag, input logic [2:0] press,
                            input logic tick, input logic [1:0] state);
    push_exp(tag, press, tick, state, exp_count);
    step();
    check_output();
  endtask

  // Expects exactly one tick, on the n-th cycle from now.
  task automatic wait_tick(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      if (i == n) exp_count++;
      step_check(tag, 3'b000, (i == n), S_RUN);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_count = 16'd0;
    rst       = 1'b1;
    enter_in  = 3'b001;
    speed_in  = 3'b000;
    stop_in   = 1'b0;

    step_check("reset", 3'b000, 1'b0, S_IDLE);
    step_check("reset_hold", 3'b000, 1'b0, S_IDLE);

    rst = 1'b0;
    for (int i = 0; i < 3; i++) step_check("held_btn", 3'b000, 1'b0, S_IDLE);
    enter_in = 3'b000;
    step_check("release", 3'b000, 1'b0, S_IDLE);
    enter_in = 3'b001;
    step_check("start", 3'b000, 1'b0, S_RUN);
    enter_in = 3'b000;

    $display("[TB] tick period at speed 0");
    wait_tick("period1", 128);
    wait_tick("period2", 128);
    wait_tick("period3", 128);

    $display("[TB] speed change mid-period");
    speed_in = 3'b011;
    wait_tick("speed_cur", 128);
    wait_tick("speed3_a", 16);
    wait_tick("speed3_b", 16);
    speed_in = 3'b000;
    wait_tick("speed_back", 16);

    $display("[TB] press forwarding and pause");
    for (int i = 0; i < 10; i++) step_check("run_quiet", 3'b000, 1'b0, S_RUN);
    enter_in = 3'b101;
    step_check("press_hi", 3'b101, 1'b0, S_RUN);
    step_check("press_once", 3'b000, 1'b0, S_RUN);
    enter_in = 3'b000;
    step_check("press_rel", 3'b000, 1'b0, S_RUN);
    for (int i = 0; i < 64; i++) step_check("pre_stop", 3'b000, 1'b0, S_RUN);
    stop_in = 1'b1;
    step_check("stop_sync1", 3'b000, 1'b0, S_RUN);
    step_check("stop_sync2", 3'b000, 1'b0, S_RUN);
    enter_in = 3'b101;
    step_check("press_stop", 3'b101, 1'b0, S_PAUSE);
    step_check("pause_hold", 3'b000, 1'b0, S_PAUSE);
    enter_in = 3'b000;
    step_check("pause_rel", 3'b000, 1'b0, S_PAUSE);
    enter_in = 3'b010;
    step_check("pause_press", 3'b000, 1'b0, S_PAUSE);
    step_check("pause_press2", 3'b000, 1'b0, S_PAUSE);
    enter_in = 3'b000;
    for (int i = 0; i < 3; i++) step_check("pause_idle", 3'b000, 1'b0, S_PAUSE);
    stop_in = 1'b0;
    step_check("resume_sync1", 3'b000, 1'b0, S_PAUSE);
    step_check("resume_sync2", 3'b000, 1'b0, S_PAUSE);
    step_check("resume", 3'b000, 1'b0, S_RUN);
    wait_tick("resume_tick", 48);

    $display("[TB] speed 7 and counter wrap");
    speed_in = 3'b111;
    wait_tick("to_speed7", 128);
    for (int i = 0; i < 4; i++) begin
      exp_count++;
      step_check("speed7", 3'b000, 1'b1, S_RUN);
    end
    for (int i = 0; i < 65521; i++) begin
      exp_count++;
      step();
    end
    exp_count++;
    step_check("pre_wrap", 3'b000, 1'b1, S_RUN);
    exp_count++;
    step_check("wrap", 3'b000, 1'b1, S_RUN);

    $display("[TB] asynchronous reset mid-run");
    exp_count = 16'd0;
    push_exp("async_rst", 3'b000, 1'b0, S_IDLE, 16'd0);
    #3;
    rst = 1'b1;
    #1;
    check_output();
    step();
    rst = 1'b0;
    step_check("after_rst", 3'b000, 1'b0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_tick_ctrl.md
# game_tick_ctrl

Control stage directly downstream of the button/switch input conditioning. It turns debounced `enter` levels into single-cycle press events and synchronises the raw `speed` and `stop` switches. It runs a three-state IDLE/RUN/PAUSE game FSM and produces a speed-scaled game tick. The game logic consumes `press_out`, `tick_out` and `state_out`.

## Interface
- `BASE_DIV`, 4_000_000: tick period in clk cycles at speed 0; must be ≥ 128.
- `CNT_W`, 32: width of the tick down-counter; must hold `BASE_DIV-1`.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `enter_in` in 3: debounced button levels, 1 = pressed, already in the `clk` domain.
- `speed_in` in 3: raw speed switches, asynchronous.
- `stop_in` in 1: raw stop switch, asynchronous, 1 = stop.
- `press_out` out 3: one-cycle press pulse per button.
- `tick_out` out 1: one-cycle game tick.
- `tick_count` out 16: number of ticks emitted, wrapping.
- `state_out` out 2: FSM state. IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10; 2'b11 is never produced.

## Operation
Synchronisers:
- `speed_in` and `stop_in` each pass through a 2-flop synchroniser, producing `speed_s` and `stop_s`.
- `enter_in` is not synchronised.

Edge detection:
- `enter_prev` registers `enter_in`.
- Edge vector: `edge = enter_in & ~enter_prev`.
- `enter_prev` resets to 3'b111, so a button held through reset never produces an edge.

Period:
- P = `BASE_DIV >> speed_s`, so speed 7 gives the shortest period.
- P is evaluated only when the counter is loaded.

FSM:
- IDLE → RUN: when any edge bit is set and `stop_s` = 0. That starting press is consumed and is not forwarded. In IDLE the counter is continuously loaded with P-1.
- RUN → PAUSE: when `stop_s` = 1.
- PAUSE → RUN: when `stop_s` = 0. The counter keeps its value, so a resume continues the interrupted period.
- IDLE is re-entered only via `rst`.
- Transitions take effect at the next clock edge. Outputs for the current cycle are computed from the current, registered state.

Counter (in RUN only):
- If cnt = 0: assert the tick and reload P-1 using the current `speed_s`. A speed change therefore takes effect at the next reload.
- Otherwise: decrement.
- In PAUSE: hold.

Outputs:
- `press_out` (registered) = `edge` when state = RUN, otherwise 0. Edges in IDLE or PAUSE are dropped, not queued.
- `tick_out` (registered): high for one cycle per counter zero reached in RUN.
- `tick_count` increments on each `tick_out` pulse; 16'hFFFF wraps to 0. It is not cleared when leaving IDLE.

## Timing
Reset values:
- state = IDLE
- `press_out` = 0, `tick_out` = 0, `tick_count` = 0
- cnt = `BASE_DIV-1`
- synchroniser flops = 0
- `enter_prev` = 3'b111

Latencies:
- Edge sampled at edge n → `press_out` high for cycle n+1 only.
- `stop_in` change → `stop_s` after 2 edges → `state_out` change at the 3rd edge.
- The first RUN cycle has cnt = P-1. The counter hits 0 in RUN cycle P, and `tick_out` is high in RUN cycle P+1. Steady state gives one tick every P cycles; P = 1 gives `tick_out` constantly high.

Simultaneous events:
- Counter zero in the same cycle `stop_s` rises (state still RUN): the tick fires and reload happens, then PAUSE.
- Press edge in the same cycle `stop_s` rises: forwarded, because state is still RUN.
- Several buttons rising together: all corresponding `press_out` bits pulse in the same cycle.
- `rst` mid-operation: all outputs clear immediately (asynchronous). In-flight pulses are lost.

## Test plan
- **Reset with button held:** `BASE_DIV` = 128; `rst` with `enter_in` = 3'b001 held through release → state stays 00 and `press_out` stays 0. Release and re-press bit 0 with `stop_in` = 0 → `state_out` = 01 one cycle later, and no `press_out` pulse for that press.
- **Tick period and count:** RUN at speed 0 → first `tick_out` in RUN cycle 129, then every 128 cycles; `tick_count` = 1, 2, 3…. Speed 7 → `tick_out` continuously high after the in-flight period ends.
- **Pause and resume:** in RUN at speed 0, `stop_in` = 1 when cnt = 50 → state = 10 three edges later, cnt frozen, presses give `press_out` = 0. `stop_in` = 0 → RUN resumes and the tick arrives after the remaining count with no restart.
- **Speed change mid-period:** change speed 0→3 mid-period → the current period completes at 128 cycles, and subsequent ticks come every 16 cycles.
- **Simultaneous press and stop:** `enter_in` 3'b000→3'b101 in RUN → `press_out` = 3'b101 for exactly one cycle, including when `stop_s` rises in the same cycle.
- **Wrap and async reset:** force 65536 ticks at speed 7 → `tick_count` wraps to 0. Assert `rst` mid-RUN between clock edges → outputs zero before the next edge.
